// File: rtl/bolt_pkg.sv
// Shared types and default borders for the player/invader bolt banks.
// The border constants are also used by the game controller.
package bolt_pkg;

    localparam int COORD_W     = 11;
    localparam int DEF_T_LIMIT = 5;
    localparam int DEF_B_LIMIT = 465;

    typedef enum logic {
        FREE   = 1'b0,
        FLYING = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        slot_state_t        state;
    } slot_t;

    // Zero-extend a screen coordinate so that compares and moves cannot wrap at 2047.
    function automatic logic [COORD_W:0] widen(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/bolt_bank_if.sv
// Controller <-> bolt bank signal bundle. The controller side is the master,
// the bank is the slave.
interface bolt_bank_if #(
    parameter int BOLT_MAX = 4
);
    import bolt_pkg::*;

    logic                frmTick;
    logic                fireCmd;
    logic [COORD_W-1:0]  fireX;
    logic [COORD_W-1:0]  fireY;
    logic [BOLT_MAX-1:0] killCmd;
    logic [COORD_W-1:0]  pixelX;
    logic [COORD_W-1:0]  pixelY;
    logic [BOLT_MAX-1:0] btReq;
    logic [BOLT_MAX-1:0] btExs;
    logic                fireAck;
    logic                fireDrop;
    logic [COORD_W-1:0]  btxLoc;
    logic [COORD_W-1:0]  btyLoc;

    modport master (
        output frmTick, fireCmd, fireX, fireY, killCmd, pixelX, pixelY,
        input  btReq, btExs, fireAck, fireDrop, btxLoc, btyLoc
    );

    modport slave (
        input  frmTick, fireCmd, fireX, fireY, killCmd, pixelX, pixelY,
        output btReq, btExs, fireAck, fireDrop, btxLoc, btyLoc
    );

endinterface

// File: rtl/bolt_slot.sv
// One bolt slot: state register, per-frame move with border kill, hit kill,
// and registered draw-request compare against the current VGA pixel.
module bolt_slot
    import bolt_pkg::*;
#(
    parameter bit DIR_DOWN = 1'b0,
    parameter int SPEED    = 4,
    parameter int BOLT_W   = 2,
    parameter int BOLT_H   = 8,
    parameter int T_LIMIT  = DEF_T_LIMIT,
    parameter int B_LIMIT  = DEF_B_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_frmTick,
    input  logic               i_kill,
    input  logic               i_launch,
    input  logic [COORD_W-1:0] i_fireX,
    input  logic [COORD_W-1:0] i_fireY,
    input  logic [COORD_W-1:0] i_pixelX,
    input  logic [COORD_W-1:0] i_pixelY,
    output logic               o_req,
    output logic               o_live,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y
);

    localparam logic [COORD_W:0] C_SPEED = (COORD_W+1)'(SPEED);
    localparam logic [COORD_W:0] C_W     = (COORD_W+1)'(BOLT_W);
    localparam logic [COORD_W:0] C_H     = (COORD_W+1)'(BOLT_H);
    localparam logic [COORD_W:0] C_TLIM  = (COORD_W+1)'(T_LIMIT);
    localparam logic [COORD_W:0] C_BLIM  = (COORD_W+1)'(B_LIMIT);

    slot_t            r_slot;
    logic             r_req;
    logic [COORD_W:0] w_ny;
    logic             w_out;
    logic             w_hit;

    // An upward underflow lands near 4095 and is caught by the bottom border test.
    always_comb begin
        if (DIR_DOWN) w_ny = widen(r_slot.y) + C_SPEED;
        else          w_ny = widen(r_slot.y) - C_SPEED;
    end

    assign w_out = (w_ny < C_TLIM) || (w_ny > C_BLIM);

    assign w_hit = (r_slot.state == FLYING)
                && (widen(i_pixelX) >= widen(r_slot.x))
                && (widen(i_pixelX) <  widen(r_slot.x) + C_W)
                && (widen(i_pixelY) >= widen(r_slot.y))
                && (widen(i_pixelY) <  widen(r_slot.y) + C_H);

    // Kill beats move; launches only ever target a slot that is already FREE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot <= '{x: '0, y: '0, state: FREE};
            r_req  <= 1'b0;
        end else begin
            r_req <= w_hit;
            if (r_slot.state == FLYING) begin
                if (i_kill) begin
                    r_slot.state <= FREE;
                end else if (i_frmTick) begin
                    if (w_out) r_slot.state <= FREE;
                    else       r_slot.y     <= w_ny[COORD_W-1:0];
                end
            end else if (i_launch) begin
                r_slot <= '{x: i_fireX, y: i_fireY, state: FLYING};
            end
        end
    end

    assign o_req  = r_req;
    assign o_live = (r_slot.state == FLYING);
    assign o_x    = r_slot.x;
    assign o_y    = r_slot.y;

endmodule

// File: rtl/bolt_bank.sv
// Bank of BOLT_MAX bolts for one owner: lowest-free-slot allocator, launch
// cooldown, ack/drop pulses and the lowest-live-slot position readout.
module bolt_bank
    import bolt_pkg::*;
#(
    parameter int BOLT_MAX = 4,
    parameter bit DIR_DOWN = 1'b0,
    parameter int SPEED    = 4,
    parameter int BOLT_W   = 2,
    parameter int BOLT_H   = 8,
    parameter int T_LIMIT  = DEF_T_LIMIT,
    parameter int B_LIMIT  = DEF_B_LIMIT,
    parameter int COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       reset,
    bolt_bank_if.slave io_bus
);

    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] C_COOL = CD_W'(COOLDOWN);

    logic [CD_W-1:0]     r_cool;
    logic                r_ack;
    logic                r_drop;
    logic [BOLT_MAX-1:0] w_live;
    logic [BOLT_MAX-1:0] w_req;
    logic [BOLT_MAX-1:0] w_grant;
    logic [BOLT_MAX-1:0] w_launch;
    logic                w_any_free;
    logic                w_accept;
    logic [COORD_W-1:0]  w_x [BOLT_MAX];
    logic [COORD_W-1:0]  w_y [BOLT_MAX];
    logic [COORD_W-1:0]  w_bx;
    logic [COORD_W-1:0]  w_by;
    logic                w_found;

    // Allocation looks at slot state before this cycle's kills, so a slot being
    // killed right now is still busy.
    always_comb begin
        w_grant    = '0;
        w_any_free = 1'b0;
        for (int i = 0; i < BOLT_MAX; i++) begin
            if (!w_live[i] && !w_any_free) begin
                w_grant[i] = 1'b1;
                w_any_free = 1'b1;
            end
        end
    end

    assign w_accept = io_bus.fireCmd && (r_cool == '0) && w_any_free;
    assign w_launch = w_accept ? w_grant : '0;

    for (genvar g = 0; g < BOLT_MAX; g++) begin : g_slot
        bolt_slot #(
            .DIR_DOWN (DIR_DOWN),
            .SPEED    (SPEED),
            .BOLT_W   (BOLT_W),
            .BOLT_H   (BOLT_H),
            .T_LIMIT  (T_LIMIT),
            .B_LIMIT  (B_LIMIT)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .i_frmTick (io_bus.frmTick),
            .i_kill    (io_bus.killCmd[g]),
            .i_launch  (w_launch[g]),
            .i_fireX   (io_bus.fireX),
            .i_fireY   (io_bus.fireY),
            .i_pixelX  (io_bus.pixelX),
            .i_pixelY  (io_bus.pixelY),
            .o_req     (w_req[g]),
            .o_live    (w_live[g]),
            .o_x       (w_x[g]),
            .o_y       (w_y[g])
        );
    end

    always_comb begin
        w_bx    = '0;
        w_by    = '0;
        w_found = 1'b0;
        for (int i = 0; i < BOLT_MAX; i++) begin
            if (w_live[i] && !w_found) begin
                w_bx    = w_x[i];
                w_by    = w_y[i];
                w_found = 1'b1;
            end
        end
    end

    // A fresh launch reloads the cooldown even on a coincident frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cool <= '0;
            r_ack  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_ack  <= w_accept;
            r_drop <= io_bus.fireCmd && !w_accept;
            if (w_accept)                             r_cool <= C_COOL;
            else if (io_bus.frmTick && r_cool != '0)  r_cool <= r_cool - 1'b1;
        end
    end

    assign io_bus.btReq    = w_req;
    assign io_bus.btExs    = w_live;
    assign io_bus.fireAck  = r_ack;
    assign io_bus.fireDrop = r_drop;
    assign io_bus.btxLoc   = w_bx;
    assign io_bus.btyLoc   = w_by;

endmodule
